// File: rtl/counter_readout.sv
// rtl/counter_readout.sv - column ADC counter latch bank with valid/ready code readout
module counter_readout #(
  parameter  int width   = 8,
  parameter  int columns = 4,
  parameter  int gray_in = 0,
  localparam int CW      = (columns > 1) ? $clog2(columns) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [width-1:0]   count_in,
  input  logic               conv_start,
  input  logic [columns-1:0] comp,
  input  logic               data_ready,
  output logic [width-1:0]   data_out,
  output logic               ovf_out,
  output logic [CW-1:0]      col_index,
  output logic               data_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, CONVERT, READOUT, FINISH} state_t;

  state_t             state, state_next;
  logic [width-1:0]   mem [columns];
  logic [columns-1:0] latched;
  logic [columns-1:0] ovf;
  logic [CW-1:0]      col;
  logic [CW-1:0]      col_next;
  logic [width-1:0]   count_bin;
  logic               terminal;
  logic               all_latched;
  logic               last_col;
  logic               transfer;

  // Each binary bit is the XOR of the Gray bits at and above it.
  if (gray_in != 0) begin : g_gray
    always_comb begin
      count_bin = '0;
      for (int i = 0; i < width; i++) count_bin[i] = ^(count_in >> i);
    end
  end else begin : g_bin
    assign count_bin = count_in;
  end

  assign terminal    = &count_bin;
  assign all_latched = &(latched | comp);
  assign last_col    = (col == CW'(columns - 1));
  assign col_next    = col + CW'(1);
  assign transfer    = data_valid & data_ready;
  assign busy        = (state == CONVERT) || (state == READOUT);
  assign done        = (state == FINISH);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FINISH is the done cycle: not busy, and not yet IDLE so conv_start is ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (conv_start) state_next = CONVERT;
      CONVERT: if (all_latched || terminal) state_next = READOUT;
      READOUT: if (transfer && last_col) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      latched    <= '0;
      ovf        <= '0;
      col        <= '0;
      data_out   <= '0;
      ovf_out    <= 1'b0;
      col_index  <= '0;
      data_valid <= 1'b0;
      for (int i = 0; i < columns; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (conv_start) begin
            latched <= '0;
            ovf     <= '0;
            col     <= '0;
          end
        end
        CONVERT: begin
          // On terminal count the decoded value is all ones, so it doubles as the saturated code.
          for (int i = 0; i < columns; i++) begin
            if (!latched[i] && (comp[i] || terminal)) begin
              mem[i]     <= count_bin;
              latched[i] <= 1'b1;
              ovf[i]     <= ~comp[i];
            end
          end
        end
        READOUT: begin
          if (!data_valid) begin
            data_valid <= 1'b1;
            data_out   <= mem[col];
            ovf_out    <= ovf[col];
            col_index  <= col;
          end else if (data_ready) begin
            if (last_col) begin
              data_valid <= 1'b0;
            end else begin
              col       <= col_next;
              data_out  <= mem[col_next];
              ovf_out   <= ovf[col_next];
              col_index <= col_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_readout.sv
// tb/tb_counter_readout.sv - directed table-driven bench for counter_readout (binary and Gray instances)
module tb_counter_readout;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] count_b;
  logic [7:0] count_g;
  logic       conv_start;
  logic [3:0] comp;
  logic       data_ready;

  logic [7:0] b_data, g_data;
  logic       b_ovf, g_ovf;
  logic [1:0] b_idx, g_idx;
  logic       b_valid, g_valid, b_busy, g_busy, b_done, g_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  counter_readout #(.width(8), .columns(4), .gray_in(0)) dut_bin (
    .clk(clk), .reset(resetn), .count_in(count_b), .conv_start(conv_start),
    .comp(comp), .data_ready(data_ready), .data_out(b_data), .ovf_out(b_ovf),
    .col_index(b_idx), .data_valid(b_valid), .busy(b_busy), .done(b_done)
  );

  counter_readout #(.width(8), .columns(4), .gray_in(1)) dut_gray (
    .clk(clk), .reset(resetn), .count_in(count_g), .conv_start(conv_start),
    .comp(comp), .data_ready(data_ready), .data_out(g_data), .ovf_out(g_ovf),
    .col_index(g_idx), .data_valid(g_valid), .busy(g_busy), .done(g_done)
  );

  typedef struct {
    int         trip [4];
    int         stall;
    int         exit_k;
    logic [7:0] d [4];
    logic [3:0] ovf;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [7:0] to_gray(input int k);
    logic [7:0] b;
    b = k[7:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int dv, input int bz, input int dn,
                            input int data, input int ov, input int idx);
    chk({tag, " bin valid"}, b_valid, dv);
    chk({tag, " gray valid"}, g_valid, dv);
    chk({tag, " bin busy"}, b_busy, bz);
    chk({tag, " gray busy"}, g_busy, bz);
    chk({tag, " bin done"}, b_done, dn);
    chk({tag, " gray done"}, g_done, dn);
    if (data >= 0) begin
      chk({tag, " bin data"}, b_data, data);
      chk({tag, " gray data"}, g_data, data);
      chk({tag, " bin ovf"}, b_ovf, ov);
      chk({tag, " gray ovf"}, g_ovf, ov);
      chk({tag, " bin idx"}, b_idx, idx);
      chk({tag, " gray idx"}, g_idx, idx);
    end
  endtask

  task automatic drive_count(input int k);
    count_b = k[7:0];
    count_g = to_gray(k);
  endtask

  // Called at a negedge in IDLE; returns at the negedge showing the done pulse.
  task automatic run_vec(input vec_t v, input string tag);
    conv_start = 1'b1;
    comp       = '0;
    data_ready = 1'b1;
    drive_count(0);
    @(negedge clk);
    conv_start = 1'b0;
    for (int k = 0; k <= v.exit_k; k++) begin
      drive_count(k);
      for (int c = 0; c < 4; c++) comp[c] = (k >= v.trip[c]);
      @(negedge clk);
      expect_out({tag, " convert"}, 0, 1, 0, -1, 0, 0);
    end
    drive_count(0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      expect_out($sformatf("%s col%0d", tag, c), 1, 1, 0, v.d[c], v.ovf[c], c);
      if (c == v.stall) begin
        data_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          expect_out($sformatf("%s stall col%0d", tag, c), 1, 1, 0, v.d[c], v.ovf[c], c);
        end
        data_ready = 1'b1;
      end
    end
    @(negedge clk);
    expect_out({tag, " done"}, 0, 0, 1, -1, 0, 0);
  endtask

  initial begin
    vecs[0] = '{trip: '{10, 200, 37, 37}, stall: -1, exit_k: 200,
                d: '{8'd10, 8'd200, 8'd37, 8'd37}, ovf: 4'b0000};
    vecs[1] = '{trip: '{5, 300, 255, 0}, stall: -1, exit_k: 255,
                d: '{8'd5, 8'd255, 8'd255, 8'd0}, ovf: 4'b0010};
    vecs[2] = '{trip: '{3, 4, 5, 6}, stall: 1, exit_k: 6,
                d: '{8'd3, 8'd4, 8'd5, 8'd6}, ovf: 4'b0000};
    vecs[3] = '{trip: '{10, 128, 128, 10}, stall: -1, exit_k: 128,
                d: '{8'd10, 8'd128, 8'd128, 8'd10}, ovf: 4'b0000};
    vecs[4] = '{trip: '{0, 0, 0, 0}, stall: -1, exit_k: 0,
                d: '{8'd0, 8'd0, 8'd0, 8'd0}, ovf: 4'b0000};

    resetn = 1'b0; conv_start = 1'b0; comp = '0; data_ready = 1'b0;
    drive_count(0);
    repeat (2) begin
      @(negedge clk);
      expect_out("reset", 0, 0, 0, 0, 0, 0);
    end
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      expect_out("idle", 0, 0, 0, 0, 0, 0);
    end

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      @(negedge clk);
      expect_out($sformatf("vec%0d post", i), 0, 0, 0, -1, 0, 0);
    end

    // conv_start during the done cycle is ignored, then accepted one cycle later.
    run_vec(vecs[4], "startdone");
    conv_start = 1'b1;
    @(negedge clk);
    expect_out("start in done", 0, 0, 0, -1, 0, 0);
    run_vec(vecs[2], "restart");
    @(negedge clk);

    // Comp glitch on column 0, then reset while column 2 is presented.
    conv_start = 1'b1;
    @(negedge clk);
    conv_start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      drive_count(k);
      comp[0]   = (k == 2) || (k >= 5);
      comp[3:1] = (k >= 8) ? 3'b111 : 3'b000;
      @(negedge clk);
      expect_out("glitch convert", 0, 1, 0, -1, 0, 0);
    end
    comp = '0;
    @(negedge clk);
    expect_out("glitch col0", 1, 1, 0, 2, 0, 0);
    @(negedge clk);
    expect_out("glitch col1", 1, 1, 0, 8, 0, 1);
    @(negedge clk);
    expect_out("glitch col2", 1, 1, 0, 8, 0, 2);
    resetn = 1'b0;
    @(negedge clk);
    expect_out("abort", 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    @(negedge clk);
    expect_out("abort idle", 0, 0, 0, 0, 0, 0);
    run_vec(vecs[0], "after abort");
    @(negedge clk);
    expect_out("after abort post", 0, 0, 0, -1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
